sm83_bus_responder: RTL and testbench

Memory-side responder for the SM83 core's data/instruction bus: accepts one read or write request at a time from the core, decodes the 16-bit address, and serves work RAM, high RAM, and the interrupt flag/enable registers with a programmable number of wait states. It is the target end of the core's PC/SP/GP16/WZ-addressed bus and owns the IF/IE state that the core consumes for interrupt dispatch.

---
 rtl/sm83_bus_responder_pkg.sv | 55 +++++
 rtl/sm83_bus_responder_if.sv | 20 ++
 rtl/sm83_spram.sv | 23 ++
 rtl/sm83_bus_responder.sv | 153 +++++++++++++++
 tb/tb_sm83_bus_responder.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm83_bus_responder_pkg.sv
// Shared SM83 bus-responder types: address/data aliases, responder FSM
// states, address regions, fixed register addresses and IRQ bit indices.
package sm83_bus_responder_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_WAIT,
    RSP_RESP
  } rsp_state_t;

  typedef enum logic [2:0] {
    RGN_WRAM,
    RGN_HRAM,
    RGN_IF,
    RGN_IE,
    RGN_ECHO,
    RGN_NONE
  } region_t;

  localparam addr_t ADDR_IF   = 16'hFF0F;
  localparam addr_t ADDR_IE   = 16'hFFFF;
  localparam addr_t WRAM_BASE = 16'hC000;
  localparam addr_t WRAM_END  = 16'hDFFF;
  localparam addr_t ECHO_BASE = 16'hE000;
  localparam addr_t ECHO_END  = 16'hFDFF;
  localparam addr_t HRAM_BASE = 16'hFF80;

  localparam int IRQ_NUM     = 5;
  localparam int IRQ_VBLANK  = 0;
  localparam int IRQ_STAT    = 1;
  localparam int IRQ_TIMER   = 2;
  localparam int IRQ_SERIAL  = 3;
  localparam int IRQ_JOYPAD  = 4;

  // Every implemented interrupt source may set its IF bit.
  localparam logic [IRQ_NUM-1:0] IRQ_MASK =
    (5'b1 << IRQ_VBLANK) | (5'b1 << IRQ_STAT) | (5'b1 << IRQ_TIMER) |
    (5'b1 << IRQ_SERIAL) | (5'b1 << IRQ_JOYPAD);

  // IE (FFFF) is checked before HRAM because FFFF lies above HRAM_BASE.
  function automatic region_t decode_region(input addr_t a);
    region_t r;
    r = RGN_NONE;
    if (a >= WRAM_BASE && a <= WRAM_END)      r = RGN_WRAM;
    else if (a >= ECHO_BASE && a <= ECHO_END) r = RGN_ECHO;
    else if (a == ADDR_IF)                    r = RGN_IF;
    else if (a == ADDR_IE)                    r = RGN_IE;
    else if (a >= HRAM_BASE)                  r = RGN_HRAM;
    return r;
  endfunction

endpackage

// File: rtl/sm83_bus_responder_if.sv
// Core-to-responder request bus.
// Handshake: req acts as valid; the core raises req with we/addr/wdata
// stable and holds it until ack. The responder captures the payload when it
// accepts (IDLE with req high), answers with a single-cycle ack, and rdata is
// valid in the ack cycle for reads. req still high in the cycle after ack is a
// new request.
interface sm83_bus_responder_if;
  import sm83_bus_responder_pkg::*;

  logic  req;
  logic  we;
  addr_t addr;
  data_t wdata;
  data_t rdata;
  logic  ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/sm83_spram.sv
// Single-port RAM: synchronous write, combinational read, contents not reset.
module sm83_spram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sm83_bus_responder.sv
// SM83 memory-side bus responder: WRAM, HRAM, IF and IE with WAIT_STATES
// extra cycles per access. Build option SM83_ECHO_RAM_EN mirrors WRAM into
// E000-FDFF; without it that range is unmapped.
module sm83_bus_responder
  import sm83_bus_responder_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int WRAM_AW     = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sm83_bus_responder_if.slave  bus,
  input  logic [IRQ_NUM-1:0]   irq_in,
  output logic [IRQ_NUM-1:0]   if_q,
  output data_t                ie_q,
  output rsp_state_t           state
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  rsp_state_t          state_r, state_n;
  logic [3:0]          cnt_r, cnt_n;
  logic                accept;
  addr_t               lat_addr;
  logic                lat_we;
  data_t               lat_wdata;
  data_t               rdata_hold, rd_mux;
  logic [IRQ_NUM-1:0]  if_r, if_n;
  data_t               ie_r;
  region_t             rgn;
  logic                commit, wram_we, hram_we;
  data_t               wram_rdata, hram_rdata;

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RSP_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Next state: accept in IDLE, count down in WAIT, one-cycle RESP.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    accept  = 1'b0;
    case (state_r)
      RSP_IDLE: begin
        if (bus.req) begin
          accept  = 1'b1;
          cnt_n   = WAIT_INIT;
          state_n = (WAIT_STATES > 0) ? RSP_WAIT : RSP_RESP;
        end
      end
      RSP_WAIT: begin
        cnt_n = cnt_r - 4'd1;
        if (cnt_r == 4'd1) state_n = RSP_RESP;
      end
      RSP_RESP: state_n = RSP_IDLE;
      default:  state_n = RSP_IDLE;
    endcase
  end

  // Request capture at accept; later bus changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_addr  <= bus.addr;
      lat_we    <= bus.we;
      lat_wdata <= bus.wdata;
    end
  end

  assign rgn     = decode_region(lat_addr);
  assign bus.ack = (state_r == RSP_RESP);
  assign commit  = bus.ack & lat_we;
  assign hram_we = commit && (rgn == RGN_HRAM);
`ifdef SM83_ECHO_RAM_EN
  assign wram_we = commit && (rgn == RGN_WRAM || rgn == RGN_ECHO);
`else
  assign wram_we = commit && (rgn == RGN_WRAM);
`endif

  sm83_spram #(.DEPTH(1 << WRAM_AW), .WIDTH(8), .AW(WRAM_AW)) u_wram (
    .clk   (clk),
    .we    (wram_we),
    .addr  (lat_addr[WRAM_AW-1:0]),
    .wdata (lat_wdata),
    .rdata (wram_rdata)
  );

  // Entry 7F would be FFFF, which is IE, so HRAM holds 127 bytes.
  sm83_spram #(.DEPTH(127), .WIDTH(8), .AW(7)) u_hram (
    .clk   (clk),
    .we    (hram_we),
    .addr  (lat_addr[6:0]),
    .wdata (lat_wdata),
    .rdata (hram_rdata)
  );

  // Read data selection by region of the latched address.
  always_comb begin
    rd_mux = 8'hFF;
    case (rgn)
      RGN_WRAM: rd_mux = wram_rdata;
`ifdef SM83_ECHO_RAM_EN
      RGN_ECHO: rd_mux = wram_rdata;
`else
      RGN_ECHO: rd_mux = 8'hFF;
`endif
      RGN_HRAM: rd_mux = hram_rdata;
      RGN_IF:   rd_mux = {3'b111, if_r};
      RGN_IE:   rd_mux = ie_r;
      default:  rd_mux = 8'hFF;
    endcase
  end

  // Read data is live during the ack cycle and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   rdata_hold <= 8'hFF;
    else if (bus.ack && !lat_we)  rdata_hold <= rd_mux;
  end

  assign bus.rdata = (bus.ack && !lat_we) ? rd_mux : rdata_hold;

  // CPU write to IF applied first so simultaneous hardware sets win.
  always_comb begin
    if_n = if_r;
    if (commit && rgn == RGN_IF) if_n = lat_wdata[IRQ_NUM-1:0];
  end

  // IF/IE registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_r <= '0;
      ie_r <= '0;
    end else begin
      if_r <= if_n | (irq_in & IRQ_MASK);
      if (commit && rgn == RGN_IE) ie_r <= lat_wdata;
    end
  end

  assign if_q  = if_r;
  assign ie_q  = ie_r;
  assign state = state_r;

endmodule

// File: tb/tb_sm83_bus_responder.sv
// Bench for sm83_bus_responder: four instances with WAIT_STATES 1, 0, 15, 4
// share clock and reset. Directed transactions push expected data and ack
// cycle into exp_q; a negedge monitor pops and compares on every ack.
`timescale 1ns/1ps
module tb_sm83_bus_responder;
  import sm83_bus_responder_pkg::*;

  localparam logic [15:0] WS_PK = {4'd4, 4'd15, 4'd0, 4'd1};
  localparam int EW = 27;  // {dut[1:0], chk, data[7:0], cycle[15:0]}

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        req_a   [4];
  logic        we_a    [4];
  logic [15:0] addr_a  [4];
  logic [7:0]  wdata_a [4];
  logic [4:0]  irq_a   [4];
  logic        ack_a   [4];
  logic [7:0]  rdata_a [4];
  logic [4:0]  ifq_a   [4];
  logic [7:0]  ieq_a   [4];
  rsp_state_t  st_a    [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    sm83_bus_responder_if bus ();
    assign bus.req     = req_a[g];
    assign bus.we      = we_a[g];
    assign bus.addr    = addr_a[g];
    assign bus.wdata   = wdata_a[g];
    assign ack_a[g]    = bus.ack;
    assign rdata_a[g]  = bus.rdata;
    sm83_bus_responder #(.WAIT_STATES(int'(WS_PK[g*4 +: 4])), .WRAM_AW(13)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus),
      .irq_in (irq_a[g]),
      .if_q   (ifq_a[g]),
      .ie_q   (ieq_a[g]),
      .state  (st_a[g])
    );
  end

  // Scoreboard
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q [$];
  string         name_q [$];
  int            ack_cnt [4] = '{default: 0};

  function automatic int ws_of(input int d);
    return int'(WS_PK[d*4 +: 4]);
  endfunction

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %02h required %02h", nm, act, ex);
    end
  endtask

  task automatic push(input int d, input logic w, input logic [7:0] ex, input int at, input string nm);
    logic [1:0] dd;
    dd = d[1:0];
    exp_q.push_back({dd, ~w, ex, 16'(at)});
    name_q.push_back(nm);
  endtask

  // Wait for ack on one instance; payload is scrambled once accepted.
  task automatic wait_ack(input int d, input string nm);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ack_a[d]) begin
        got = 1'b1;
        break;
      end
      if (n >= 1) begin
        addr_a[d]  = 16'($urandom_range(0, 65535));
        wdata_a[d] = 8'($urandom_range(0, 255));
        we_a[d]    = 1'($urandom_range(0, 1));
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no ack from dut%0d within 40 cycles", nm, d);
    end
  endtask

  // Driver tasks
  task automatic drive(input int d, input logic w, input logic [15:0] a, input logic [7:0] wd);
    req_a[d] = 1'b1; we_a[d] = w; addr_a[d] = a; wdata_a[d] = wd;
  endtask

  task automatic txn(input int d, input logic w, input logic [15:0] a, input logic [7:0] wd,
                     input logic [7:0] ex, input string nm);
    @(posedge clk); #1;
    push(d, w, ex, cyc + 1 + ws_of(d), nm);
    drive(d, w, a, wd);
    wait_ack(d, nm);
    @(posedge clk); #1;
    req_a[d] = 1'b0;
  endtask

  task automatic b2b(input int d,
                     input logic w1, input logic [15:0] a1, input logic [7:0] wd1, input logic [7:0] ex1, input string n1,
                     input logic w2, input logic [15:0] a2, input logic [7:0] wd2, input logic [7:0] ex2, input string n2);
    int k;
    @(posedge clk); #1;
    k = cyc;
    push(d, w1, ex1, k + 1 + ws_of(d), n1);
    push(d, w2, ex2, k + 3 + 2 * ws_of(d), n2);
    drive(d, w1, a1, wd1);
    wait_ack(d, n1);
    @(posedge clk); #1;
    drive(d, w2, a2, wd2);
    wait_ack(d, n2);
    @(posedge clk); #1;
    req_a[d] = 1'b0;
  endtask

  // Write to C000 on dut d, reset during WAIT; no ack may follow.
  task automatic abort_write(input int d, input logic [7:0] wd);
    int snap;
    snap = ack_cnt[d];
    @(posedge clk); #1;
    drive(d, 1'b1, 16'hC000, wd);
    @(posedge clk); #1;
    @(negedge clk);
    check8("abort_in_wait", {6'd0, st_a[d]}, {6'd0, RSP_WAIT});
    rst_n = 1'b0;
    req_a[d] = 1'b0;
    #1;
    check8("abort_state_idle", {6'd0, st_a[d]}, {6'd0, RSP_IDLE});
    check8("abort_ack_low", {7'd0, ack_a[d]}, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check8("abort_no_ack", 8'(ack_cnt[d] - snap), 8'h00);
  endtask

  // Monitor: pop and compare on every ack.
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    string nm;
    for (int i = 0; i < 4; i++) begin
      if (ack_a[i] === 1'b1) begin
        ack_cnt[i]++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: dut%0d ack at cycle %0d, required none", i, cyc);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (e[26:25] != 2'(i) || e[15:0] != cyc[15:0]) begin
            errors++;
            $display("FAIL %s latency: dut%0d ack at cycle %0d, required dut%0d at cycle %0d",
                     nm, i, cyc[15:0], e[26:25], e[15:0]);
          end
          if (e[24]) begin
            checks++;
            if (rdata_a[i] !== e[23:16]) begin
              errors++;
              $display("FAIL %s data: got %02h required %02h", nm, rdata_a[i], e[23:16]);
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_a[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = '0; wdata_a[i] = '0; irq_a[i] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check8("rst_ack", {7'd0, ack_a[i]}, 8'h00);
      check8("rst_rdata", rdata_a[i], 8'hFF);
      check8("rst_if", {3'd0, ifq_a[i]}, 8'h00);
      check8("rst_ie", ieq_a[i], 8'h00);
      check8("rst_state", {6'd0, st_a[i]}, {6'd0, RSP_IDLE});
    end

    // Registers and RAM on the WAIT_STATES=1 instance
    txn(0, 1'b0, 16'hFFFF, 8'h00, 8'h00, "rd_ie_rst");
    txn(0, 1'b0, 16'hFF0F, 8'h00, 8'hE0, "rd_if_rst");
    txn(0, 1'b1, 16'hC123, 8'h5A, 8'h00, "wr_c123");
    txn(0, 1'b0, 16'hC123, 8'h00, 8'h5A, "rd_c123");
    txn(0, 1'b1, 16'hDFFF, 8'hA5, 8'h00, "wr_dfff");
    txn(0, 1'b0, 16'hDFFF, 8'h00, 8'hA5, "rd_dfff");
    txn(0, 1'b0, 16'h0100, 8'h00, 8'hFF, "rd_unmapped");
    txn(0, 1'b1, 16'h0100, 8'h42, 8'h00, "wr_unmapped");
    txn(0, 1'b0, 16'h0100, 8'h00, 8'hFF, "rd_unmapped2");
    txn(0, 1'b1, 16'hFF80, 8'h3C, 8'h00, "wr_ff80");
    txn(0, 1'b1, 16'hFFFE, 8'hC3, 8'h00, "wr_fffe");
    txn(0, 1'b0, 16'hFF80, 8'h00, 8'h3C, "rd_ff80");
    txn(0, 1'b0, 16'hFFFE, 8'h00, 8'hC3, "rd_fffe");
    txn(0, 1'b1, 16'hFFFF, 8'h9B, 8'h00, "wr_ie");
    txn(0, 1'b0, 16'hFFFF, 8'h00, 8'h9B, "rd_ie");
    @(negedge clk);
    check8("ie_q", ieq_a[0], 8'h9B);

    // Echo region
    txn(0, 1'b1, 16'hE123, 8'h77, 8'h00, "wr_e123");
`ifdef SM83_ECHO_RAM_EN
    txn(0, 1'b0, 16'hC123, 8'h00, 8'h77, "rd_c123_echo");
    txn(0, 1'b0, 16'hE123, 8'h00, 8'h77, "rd_e123");
`else
    txn(0, 1'b0, 16'hC123, 8'h00, 8'h5A, "rd_c123_noecho");
    txn(0, 1'b0, 16'hE123, 8'h00, 8'hFF, "rd_e123");
`endif

    // IF: CPU write, collision with hardware set, level sampling
    txn(0, 1'b1, 16'hFF0F, 8'h1F, 8'h00, "wr_if_1f");
    @(negedge clk);
    check8("if_q_1f", {3'd0, ifq_a[0]}, 8'h1F);
    txn(0, 1'b0, 16'hFF0F, 8'h00, 8'hFF, "rd_if_1f");
    fork
      txn(0, 1'b1, 16'hFF0F, 8'h00, 8'h00, "wr_if_collide");
      begin
        for (int n = 0; n < 40; n++) begin
          @(negedge clk);
          if (ack_a[0]) break;
        end
        irq_a[0] = 5'b00100;
        @(posedge clk); #1;
        irq_a[0] = '0;
      end
    join
    @(negedge clk);
    check8("if_q_collide", {3'd0, ifq_a[0]}, 8'h04);
    txn(0, 1'b0, 16'hFF0F, 8'h00, 8'hE4, "rd_if_collide");
    txn(0, 1'b1, 16'hFF0F, 8'h00, 8'h00, "wr_if_00");
    @(posedge clk); #1;
    irq_a[0] = 5'b01001;
    @(posedge clk); #1;
    irq_a[0] = '0;
    @(negedge clk);
    check8("if_q_level", {3'd0, ifq_a[0]}, 8'h09);
    txn(0, 1'b0, 16'hFF0F, 8'h00, 8'hE9, "rd_if_level");

    // Back-to-back with req held high
    b2b(0, 1'b0, 16'hDFFF, 8'h00, 8'hA5, "b2b_rd_dfff", 1'b0, 16'hFF80, 8'h00, 8'h3C, "b2b_rd_ff80");
    b2b(0, 1'b1, 16'hC200, 8'h66, 8'h00, "b2b_wr_c200", 1'b0, 16'hC200, 8'h00, 8'h66, "b2b_rd_c200");

    // WAIT_STATES=0
    txn(1, 1'b0, 16'hFFFF, 8'h00, 8'h00, "ws0_rd_ie");
    txn(1, 1'b1, 16'hC000, 8'h12, 8'h00, "ws0_wr_c000");
    txn(1, 1'b0, 16'hC000, 8'h00, 8'h12, "ws0_rd_c000");
    b2b(1, 1'b0, 16'hC000, 8'h00, 8'h12, "ws0_b2b_1", 1'b0, 16'hFF0F, 8'h00, 8'hE0, "ws0_b2b_2");

    // WAIT_STATES=15
    txn(2, 1'b0, 16'hFFFF, 8'h00, 8'h00, "ws15_rd_ie");
    txn(2, 1'b1, 16'hD000, 8'h34, 8'h00, "ws15_wr_d000");
    txn(2, 1'b0, 16'hD000, 8'h00, 8'h34, "ws15_rd_d000");
    b2b(2, 1'b0, 16'hD000, 8'h00, 8'h34, "ws15_b2b_1", 1'b0, 16'h0100, 8'h00, 8'hFF, "ws15_b2b_2");

    // Reset during WAIT on the WAIT_STATES=4 instance
    abort_write(3, 8'h11);
    txn(3, 1'b1, 16'hC000, 8'h00, 8'h00, "ws4_init_c000");
    abort_write(3, 8'h11);
    txn(3, 1'b0, 16'hC000, 8'h00, 8'h00, "ws4_rd_c000_after_abort");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_acks: %0d expected acks never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
